// File: rtl/seq_pkg.sv
// Shared types and constants for the accelerator run sequencer.
package seq_pkg;
  typedef enum logic [3:0] {
    IDLE, LD_WAIT, LD_ACC, START, RUN, RD_REQ, RD_ACC, RD_OUT, FIN
  } seq_state_e;

  localparam int LANE_W             = 64;
  localparam int SIZE_W             = 7;
  localparam int DEF_TIMEOUT_CYCLES = 200000000;
endpackage

// File: rtl/accel_run_sequencer_if.sv
// Host command/stream, accelerator start/done, slave memory bus and status bundle.
interface accel_run_sequencer_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic                           cmd_valid;
  logic                           cmd_ready;
  logic [ADDR_W-1:0]              cmd_base;
  logic [7:0]                     cmd_nld;
  logic [7:0]                     cmd_nrd;
  logic                           ld_valid;
  logic                           ld_ready;
  logic [DATA_W-1:0]              ld_data;
  logic                           rd_valid;
  logic                           rd_ready;
  logic [DATA_W-1:0]              rd_data;
  logic                           start_port;
  logic                           done_port;
  logic [1:0]                     S_oe_ram;
  logic [1:0]                     S_we_ram;
  logic [2*ADDR_W-1:0]            S_addr_ram;
  logic [2*seq_pkg::LANE_W-1:0]   S_Wdata_ram;
  logic [2*seq_pkg::SIZE_W-1:0]   S_data_ram_size;
  logic [2*seq_pkg::LANE_W-1:0]   Sout_Rdata_ram;
  logic [1:0]                     Sout_DataRdy;
  logic                           busy;
  logic                           run_ok;
  logic                           run_timeout;
  logic [31:0]                    cycles;

  modport slave (
    input  cmd_valid, cmd_base, cmd_nld, cmd_nrd, ld_valid, ld_data, rd_ready,
           done_port, Sout_Rdata_ram, Sout_DataRdy,
    output cmd_ready, ld_ready, rd_valid, rd_data, start_port, S_oe_ram, S_we_ram,
           S_addr_ram, S_Wdata_ram, S_data_ram_size, busy, run_ok, run_timeout, cycles
  );

  modport master (
    output cmd_valid, cmd_base, cmd_nld, cmd_nrd, ld_valid, ld_data, rd_ready,
           done_port, Sout_Rdata_ram, Sout_DataRdy,
    input  cmd_ready, ld_ready, rd_valid, rd_data, start_port, S_oe_ram, S_we_ram,
           S_addr_ram, S_Wdata_ram, S_data_ram_size, busy, run_ok, run_timeout, cycles
  );
endinterface

// File: rtl/accel_run_sequencer_slave_port.sv
// Maps the sequencer's registered strobes onto lane 0 of the two-channel slave bus.
// Combinational pass-through; completion only counts while a strobe is up.
module slave_port_if
  import seq_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   we,
  input  logic                   oe,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wdata,
  output logic                   acc_done,
  output logic [DATA_W-1:0]      rdata,
  output logic [1:0]             S_oe_ram,
  output logic [1:0]             S_we_ram,
  output logic [2*ADDR_W-1:0]    S_addr_ram,
  output logic [2*LANE_W-1:0]    S_Wdata_ram,
  output logic [2*SIZE_W-1:0]    S_data_ram_size,
  input  logic [2*LANE_W-1:0]    Sout_Rdata_ram,
  input  logic [1:0]             Sout_DataRdy
);
  logic live;
  logic unused_bits;

  // Size lane reads zero while held in reset so every output is quiet then.
  always_ff @(posedge clock) begin
    if (!reset) live <= 1'b0;
    else        live <= 1'b1;
  end

  assign S_we_ram        = {1'b0, we};
  assign S_oe_ram        = {1'b0, oe};
  assign S_addr_ram      = {{ADDR_W{1'b0}}, addr};
  assign S_Wdata_ram     = {{LANE_W{1'b0}}, LANE_W'(wdata)};
  assign S_data_ram_size = {{SIZE_W{1'b0}}, (live ? SIZE_W'(DATA_W) : {SIZE_W{1'b0}})};

  // A ready pulse with no strobe up belongs to nobody and is dropped.
  assign acc_done = (we | oe) & Sout_DataRdy[0];
  assign rdata    = Sout_Rdata_ram[DATA_W-1:0];

  assign unused_bits = ^{Sout_DataRdy[1], Sout_Rdata_ram[2*LANE_W-1:DATA_W]};
endmodule

// File: rtl/accel_run_sequencer.sv
// Preloads accelerator memory, pulses start, times the run, then streams readback words.
// One word in flight on the slave bus; ld/rd streams stall on valid/ready, run bounded by timeout.
module accel_run_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  accel_run_sequencer_if.slave  bus
);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(DATA_W / 8);
  localparam logic [31:0]       TO_LIM = 32'(TIMEOUT_CYCLES);

  seq_state_e        state, nxt;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [7:0]        nld_left, nrd_left;
  logic [DATA_W-1:0] wdata_q, rd_data_q;
  logic              we_q, oe_q;
  logic              cmd_ready_q, ld_ready_q, rd_valid_q, start_q;
  logic              busy_q, run_ok_q, run_to_q;
  logic [31:0]       cycles_q;
  logic              acc_done;
  logic [DATA_W-1:0] rdata;
  seq_state_e        after_run;

  assign after_run = (nrd_left != 8'd0) ? RD_REQ : FIN;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid && cmd_ready_q) nxt = (bus.cmd_nld != 8'd0) ? LD_WAIT : START;
      LD_WAIT: if (bus.ld_valid) nxt = LD_ACC;
      LD_ACC:  if (acc_done) nxt = (nld_left == 8'd1) ? START : LD_WAIT;
      START:   nxt = bus.done_port ? after_run : RUN;
      RUN: begin
        if (bus.done_port)          nxt = after_run;
        else if (cycles_q == TO_LIM) nxt = FIN;
      end
      RD_REQ:  nxt = RD_ACC;
      RD_ACC:  if (acc_done) nxt = RD_OUT;
      RD_OUT:  if (bus.rd_ready) nxt = (nrd_left == 8'd1) ? FIN : RD_REQ;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      nld_left    <= '0;
      nrd_left    <= '0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      cmd_ready_q <= 1'b0;
      ld_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      run_ok_q    <= 1'b0;
      run_to_q    <= 1'b0;
      cycles_q    <= '0;
    end else begin
      state       <= nxt;
      busy_q      <= (nxt != IDLE);
      cmd_ready_q <= (nxt == IDLE);
      ld_ready_q  <= (nxt == LD_WAIT);
      start_q     <= (nxt == START);
      case (state)
        IDLE: if (bus.cmd_valid && cmd_ready_q) begin
          base_q   <= bus.cmd_base;
          addr_q   <= bus.cmd_base;
          nld_left <= bus.cmd_nld;
          nrd_left <= bus.cmd_nrd;
          run_ok_q <= 1'b0;
          run_to_q <= 1'b0;
          cycles_q <= '0;
        end
        LD_WAIT: if (bus.ld_valid) begin
          wdata_q <= bus.ld_data;
          we_q    <= 1'b1;
        end
        LD_ACC: if (acc_done) begin
          we_q     <= 1'b0;
          addr_q   <= addr_q + STEP;
          nld_left <= nld_left - 8'd1;
        end
        START: begin
          // Readback walks the same window the preload filled.
          addr_q   <= base_q;
          cycles_q <= 32'd1;
          if (bus.done_port) run_ok_q <= 1'b1;
        end
        RUN: begin
          if (bus.done_port)           run_ok_q <= 1'b1;
          else if (cycles_q == TO_LIM) run_to_q <= 1'b1;
          else                         cycles_q <= cycles_q + 32'd1;
        end
        RD_REQ: oe_q <= 1'b1;
        RD_ACC: if (acc_done) begin
          oe_q       <= 1'b0;
          rd_data_q  <= rdata;
          rd_valid_q <= 1'b1;
        end
        RD_OUT: if (bus.rd_ready) begin
          rd_valid_q <= 1'b0;
          addr_q     <= addr_q + STEP;
          nrd_left   <= nrd_left - 8'd1;
        end
        default: ;
      endcase
    end
  end

  slave_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slave (
    .clock           (clock),
    .reset           (reset),
    .we              (we_q),
    .oe              (oe_q),
    .addr            (addr_q),
    .wdata           (wdata_q),
    .acc_done        (acc_done),
    .rdata           (rdata),
    .S_oe_ram        (bus.S_oe_ram),
    .S_we_ram        (bus.S_we_ram),
    .S_addr_ram      (bus.S_addr_ram),
    .S_Wdata_ram     (bus.S_Wdata_ram),
    .S_data_ram_size (bus.S_data_ram_size),
    .Sout_Rdata_ram  (bus.Sout_Rdata_ram),
    .Sout_DataRdy    (bus.Sout_DataRdy)
  );

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.ld_ready    = ld_ready_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.start_port  = start_q;
  assign bus.busy        = busy_q;
  assign bus.run_ok      = run_ok_q;
  assign bus.run_timeout = run_to_q;
  assign bus.cycles      = cycles_q;
endmodule

// File: tb/tb_accel_run_sequencer.sv
// Bench: slave memory model, command vector table plus random commands, reset abort sequence.
module tb_accel_run_sequencer;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int TO = 50;
  localparam int BUDGET = 1500;

  typedef struct {
    logic [AW-1:0] base;
    int nld, nrd, d, wd, rdl, stall, rst_at;
    bit e_ok, e_to;
    int e_cyc;
  } vec_t;

  logic clock, reset;
  int checks = 0, failures = 0;

  accel_run_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  accel_run_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .bus(bus));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic [31:0] smem [512];
  logic [31:0] ref_mem [512];
  logic [AW-1:0] wr_addr_q [$];
  logic [31:0]   wr_data_q [$];
  int rd_acc_cnt = 0, wdelay = 1, rdelay = 2, scnt = 0;
  bit spurious = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Slave memory: answers a held strobe after wdelay/rdelay cycles with a one-cycle ready.
  initial begin
    bus.Sout_DataRdy = 2'b00;
    bus.Sout_Rdata_ram = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        bus.Sout_DataRdy = 2'b00;
        scnt = 0;
      end else if (bus.Sout_DataRdy[0]) begin
        bus.Sout_DataRdy = 2'b00;
        scnt = 0;
      end else if (bus.S_we_ram[0] || bus.S_oe_ram[0]) begin
        scnt++;
        if (scnt >= (bus.S_we_ram[0] ? wdelay : rdelay)) begin
          if (bus.S_we_ram[0]) begin
            smem[bus.S_addr_ram[AW-1:0]] = bus.S_Wdata_ram[31:0];
            wr_addr_q.push_back(bus.S_addr_ram[AW-1:0]);
            wr_data_q.push_back(bus.S_Wdata_ram[31:0]);
          end else begin
            bus.Sout_Rdata_ram = {$urandom, $urandom, $urandom, smem[bus.S_addr_ram[AW-1:0]]};
            rd_acc_cnt++;
          end
          bus.Sout_DataRdy = 2'b01;
        end
      end else begin
        scnt = 0;
        if (spurious && ($urandom % 8 == 0)) begin
          bus.Sout_Rdata_ram = {$urandom, $urandom, $urandom, $urandom};
          bus.Sout_DataRdy = 2'b01;
        end
      end
    end
  end

  // Run outcome from the done delay d (cycles from the start pulse to done rising).
  function automatic void model_run(input int d, output bit ok, output bit to, output int cyc);
    if (d <= TO) begin ok = 1; to = 0; cyc = (d < 1) ? 1 : d; end
    else         begin ok = 0; to = 1; cyc = TO; end
  endfunction

  task automatic run_cmd(input vec_t v, input string tag);
    logic [31:0] ldw [$];
    logic [31:0] rd_exp [$];
    bit fired = 0, started = 0, finished = 0, aborted = 0;
    bit p_cv = 0, p_cr = 0, p_lv = 0, p_lr = 0, p_rv = 0, p_rr = 0;
    logic [31:0] p_rd = '0;
    int ld_idx = 0, rd_got = 0, start_cnt = 0, start_cyc = 0, wait_cnt = 0;
    logic [AW-1:0] a;
    for (int i = 0; i < v.nld; i++) begin
      a = v.base + AW'(4 * i);
      ldw.push_back($urandom);
      ref_mem[a] = ldw[i];
    end
    if (v.e_ok)
      for (int j = 0; j < v.nrd; j++) begin
        a = v.base + AW'(4 * j);
        rd_exp.push_back(ref_mem[a]);
      end
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_acc_cnt = 0;
    wdelay = v.wd;
    rdelay = v.rdl;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clock);
      if (p_cv && p_cr) begin
        fired = 1;
        bus.cmd_valid = 0;
        chk({tag, "_clr_ok"}, 64'(bus.run_ok), 0);
        chk({tag, "_clr_to"}, 64'(bus.run_timeout), 0);
        chk({tag, "_clr_cyc"}, 64'(bus.cycles), 0);
        chk({tag, "_busy"}, 64'(bus.busy), 1);
      end
      if (p_lv && p_lr) ld_idx++;
      if (p_rv && p_rr) begin
        if (rd_got < rd_exp.size()) chk($sformatf("%s_rd%0d", tag, rd_got), 64'(p_rd), 64'(rd_exp[rd_got]));
        else chk({tag, "_rd_extra"}, 1, 0);
        rd_got++;
        wait_cnt = 0;
      end else if (p_rv) begin
        chk({tag, "_rd_hold_v"}, 64'(bus.rd_valid), 1);
        chk({tag, "_rd_hold_d"}, 64'(bus.rd_data), 64'(p_rd));
      end
      if (fired && !bus.busy) begin finished = 1; break; end
      if (!fired) begin
        bus.cmd_valid = 1;
        bus.cmd_base  = v.base;
        bus.cmd_nld   = 8'(v.nld);
        bus.cmd_nrd   = 8'(v.nrd);
      end
      if (fired && ld_idx < v.nld) begin
        if (!bus.ld_valid) bus.ld_valid = ($urandom % 4 != 0);
        bus.ld_data = ldw[ld_idx];
      end else bus.ld_valid = 0;
      if (bus.start_port) begin
        start_cnt++;
        if (!started) begin started = 1; start_cyc = cyc; end
      end
      if (started && (cyc - start_cyc) >= v.d) bus.done_port = 1;
      if (v.rst_at > 0 && started && (cyc - start_cyc) == v.rst_at) begin
        reset = 0;
        aborted = 1;
        break;
      end
      case (v.stall)
        0: bus.rd_ready = 1;
        1: if (bus.rd_valid) begin bus.rd_ready = (wait_cnt >= 5); wait_cnt++; end
           else bus.rd_ready = 0;
        default: bus.rd_ready = ($urandom % 2 == 0);
      endcase
      if (bus.rd_valid) chk({tag, "_no_oe_in_out"}, 64'(bus.S_oe_ram[0]), 0);
      chk({tag, "_strobes"}, 64'({bus.S_we_ram[0] & bus.S_oe_ram[0], bus.S_we_ram[1], bus.S_oe_ram[1]}), 0);
      p_cv = bus.cmd_valid;  p_cr = bus.cmd_ready;
      p_lv = bus.ld_valid;   p_lr = bus.ld_ready;
      p_rv = bus.rd_valid;   p_rr = bus.rd_ready;
      p_rd = bus.rd_data;
    end
    bus.cmd_valid = 0;
    bus.ld_valid  = 0;
    bus.rd_ready  = 0;
    bus.done_port = 0;
    if (!finished && !aborted) chk({tag, "_budget"}, 1, 0);
    if (finished) begin
      chk({tag, "_run_ok"}, 64'(bus.run_ok), 64'(v.e_ok));
      chk({tag, "_run_to"}, 64'(bus.run_timeout), 64'(v.e_to));
      chk({tag, "_cycles"}, 64'(bus.cycles), 64'(v.e_cyc));
      chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 1);
      chk({tag, "_start_cnt"}, 64'(start_cnt), 1);
      chk({tag, "_we_cnt"}, 64'(wr_addr_q.size()), 64'(v.nld));
      for (int i = 0; i < v.nld && i < wr_addr_q.size(); i++) begin
        a = v.base + AW'(4 * i);
        chk($sformatf("%s_wa%0d", tag, i), 64'(wr_addr_q[i]), 64'(a));
        chk($sformatf("%s_wd%0d", tag, i), 64'(wr_data_q[i]), 64'(ldw[i]));
      end
      chk({tag, "_oe_cnt"}, 64'(rd_acc_cnt), 64'(v.e_ok ? v.nrd : 0));
      chk({tag, "_rd_cnt"}, 64'(rd_got), 64'(rd_exp.size()));
    end
  endtask

  vec_t tbl [8];
  vec_t rv;

  initial begin
    reset = 0;
    bus.cmd_valid = 0; bus.cmd_base = '0; bus.cmd_nld = '0; bus.cmd_nrd = '0;
    bus.ld_valid = 0;  bus.ld_data = '0;  bus.rd_ready = 0; bus.done_port = 0;
    for (int i = 0; i < 512; i++) begin
      smem[i] = $urandom;
      ref_mem[i] = smem[i];
    end
    //           base    nld nrd  d   wd rdl st rst  ok to cyc
    tbl[0] = '{9'd0,    4,  0,  3,  1, 2, 0, 0, 1, 0, 3};
    tbl[1] = '{9'd0,    2,  2,  10, 1, 2, 0, 0, 1, 0, 10};
    tbl[2] = '{9'd16,   0,  3,  999,1, 2, 0, 0, 0, 1, 50};
    tbl[3] = '{9'd100,  1,  2,  0,  2, 2, 1, 0, 1, 0, 1};
    tbl[4] = '{9'd508,  2,  2,  50, 1, 2, 0, 0, 1, 0, 50};
    tbl[5] = '{9'd40,   0,  1,  51, 1, 1, 0, 0, 0, 1, 50};
    tbl[6] = '{9'd8,    3,  3,  1,  3, 1, 2, 0, 1, 0, 1};
    tbl[7] = '{9'd200,  0,  0,  7,  1, 2, 0, 0, 1, 0, 7};

    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 0);
    chk("rst_start", 64'(bus.start_port), 0);
    chk("rst_strobes", 64'({bus.S_we_ram, bus.S_oe_ram}), 0);
    chk("rst_size", 64'(bus.S_data_ram_size), 0);
    chk("rst_status", 64'({bus.run_ok, bus.run_timeout, bus.rd_valid, bus.ld_ready}), 0);
    chk("rst_cycles", 64'(bus.cycles), 0);
    reset = 1;
    @(negedge clock);
    chk("rel_cmd_ready", 64'(bus.cmd_ready), 1);
    chk("rel_size", 64'(bus.S_data_ram_size), 64'(DW));
    spurious = 1;

    for (int k = 0; k < 8; k++) run_cmd(tbl[k], $sformatf("vec%0d", k));

    // Abort in the middle of the run, then a fresh command must go through.
    rv = '{9'd60, 1, 1, 999, 1, 2, 0, 5, 0, 0, 0};
    run_cmd(rv, "abort");
    @(negedge clock);
    chk("abort_busy", 64'(bus.busy), 0);
    chk("abort_cmd_ready", 64'(bus.cmd_ready), 0);
    chk("abort_outs", 64'({bus.start_port, bus.S_we_ram, bus.S_oe_ram, bus.rd_valid, bus.ld_ready}), 0);
    chk("abort_cycles", 64'(bus.cycles), 0);
    reset = 1;
    @(negedge clock);
    chk("abort_rel_ready", 64'(bus.cmd_ready), 1);
    run_cmd(tbl[1], "after_abort");

    for (int k = 0; k < 25; k++) begin
      rv.base  = AW'($urandom_range(0, 127) * 4);
      rv.nld   = $urandom_range(0, 6);
      rv.nrd   = $urandom_range(0, 6);
      case ($urandom % 4)
        0, 1: rv.d = $urandom_range(0, 12);
        2:    rv.d = $urandom_range(TO - 2, TO + 2);
        default: rv.d = 999;
      endcase
      rv.wd     = $urandom_range(1, 3);
      rv.rdl    = $urandom_range(1, 3);
      rv.stall  = $urandom_range(0, 2);
      rv.rst_at = 0;
      model_run(rv.d, rv.e_ok, rv.e_to, rv.e_cyc);
      run_cmd(rv, $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/accel_run_sequencer.md
ACCEL_RUN_SEQUENCER -- requirements
Module: accel_run_sequencer

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 9, per-channel slave address width; DATA_W, default 32, transfer word width; TIMEOUT_CYCLES, default 200000000, run-phase cycle limit.
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; a command is accepted when both are high on a clock edge.
REQ-005 cmd_base  in  ADDR_W  byte address of the first load/readback word.
REQ-006 cmd_nld / cmd_nrd  in  8 each  number of words to preload / read back; 0 is legal.
REQ-007 ld_valid / ld_ready / ld_data  in / out / in  1 / 1 / DATA_W  preload word stream.
REQ-008 rd_valid / rd_ready / rd_data  out / in / out  1 / 1 / DATA_W  readback word stream.
REQ-009 start_port / done_port  out / in  1 / 1  accelerator start pulse / accelerator completion.
REQ-010 S_oe_ram, S_we_ram  out  2 each  slave read/write strobes; only bit 0 is driven, bit 1 is tied to 0.
REQ-011 S_addr_ram  out  2*ADDR_W  slave address; upper channel tied to 0.
REQ-012 S_Wdata_ram  out  2*64  slave write data; lane 0 carries ld_data zero-extended, upper lane tied to 0.
REQ-013 S_data_ram_size  out  2*7  slave access size; lane 0 = DATA_W, upper lane 0.
REQ-014 Sout_Rdata_ram / Sout_DataRdy  in  2*64 / 2  slave read data / per-channel access completion; only lane 0 is used.
REQ-015 busy, run_ok, run_timeout  out  1 each  status flags; cycles  out  32  measured run length.

Function
REQ-016 States SHALL be: IDLE, LD_WAIT, LD_ACC, START, RUN, RD_REQ, RD_ACC, RD_OUT, FIN.
REQ-017 IDLE: cmd_ready=1; on accept, latch base/nld/nrd, clear run_ok/run_timeout/cycles, and go to LD_WAIT (nld>0) or START (nld=0).
REQ-018 LD_WAIT: ld_ready=1; on ld_valid, capture data, assert S_we_ram[0] with the address, and go to LD_ACC.
REQ-019 LD_ACC: hold we/addr/data until Sout_DataRdy[0]=1, then drop we. If words remain, go to LD_WAIT; otherwise go to START.
REQ-020 The address SHALL advance by DATA_W/8 per word and wrap modulo 2^ADDR_W.
REQ-021 START: start_port=1 for exactly one cycle, then go to RUN; the cycle counter is loaded with 1.
REQ-022 RUN: cycles increments each cycle until done_port=1. On done, run_ok=1 and the next state is RD_REQ (nrd>0) or FIN (nrd=0).
REQ-023 Timeout: if cycles reaches TIMEOUT_CYCLES in RUN without done_port, set run_timeout=1, skip readback, and go to FIN.
REQ-024 done_port in the START cycle SHALL be treated as done, with cycles=1.
REQ-025 RD_REQ/RD_ACC: assert S_oe_ram[0] with the address until Sout_DataRdy[0]. Capture Sout_Rdata_ram[DATA_W-1:0] and go to RD_OUT. The bench memory read delay is 2 cycles; the block SHALL tolerate any delay of 1 cycle or more.
REQ-026 RD_OUT: rd_valid=1 with stable data until rd_ready. Then go to RD_REQ if words remain, otherwise to FIN.
REQ-027 FIN: hold for one cycle, then go to IDLE. Status flags and cycles are held until the next command is accepted.
REQ-028 busy=1 in every state except IDLE. At most one slave strobe is high in any cycle. Strobes are registered outputs.
REQ-029 Sout_DataRdy[0] seen outside LD_ACC/RD_ACC SHALL be ignored.

Reset
REQ-030 When reset=0 at a clock edge: state=IDLE; every output = 0 (cmd_ready becomes 1 the cycle after release); counters and latches = 0.
REQ-031 Reset mid-operation SHALL abort the transfer immediately and drop strobes/start_port that cycle. No handshake completes during reset.

Structure
REQ-032 A shared package seq_pkg SHALL hold the state enum, the slave lane width (64), the size width (7) and the default TIMEOUT_CYCLES.
REQ-033 One sub-module, slave_port_if, SHALL drive strobes/address/size and detect completion. The FSM and counters stay in the top.

Verification
REQ-034 Preload: base=0, nld=4, nrd=0, memory model with a 1-cycle write delay → 4 we pulses at 0,4,8,12, then start_port pulses once.
REQ-035 Full run: nld=2, nrd=2, done_port 10 cycles after start → run_ok=1, cycles=10, rd_data matches the model contents at 0 and 4.
REQ-036 Timeout: TIMEOUT_CYCLES=50, done_port never rises → run_timeout=1, cycles=50, no S_oe_ram asserted, back to IDLE.
REQ-037 Backpressure: rd_ready held low for 5 cycles → rd_valid and rd_data stay stable, and no further oe is issued.
REQ-038 Wrap: base=2^ADDR_W-4, nld=2 → addresses 508 then 0.
REQ-039 Reset asserted during RUN → outputs 0 next cycle; a new command is then accepted normally.
